// File: rtl/rxfifo_if.sv
// rxfifo_if: valid/ready byte channel between the UART receiver, the rxfifo
// and the command decoder.
//   wdata/wen     : write side, one-cycle strobe per received byte
//   rdata/rvalid  : head entry presented by the FIFO
//   rready        : consumer accepts the head entry
// master = producer/consumer side, slave = FIFO side.
interface rxfifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] wdata;
  logic             wen;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;
  logic             rready;

  modport master (output wdata, output wen, output rready,
                  input rdata, input rvalid);
  modport slave  (input wdata, input wen, input rready,
                  output rdata, output rvalid);
endinterface

// File: rtl/rxfifo.sv
// rxfifo: byte-wide first-word-fall-through FIFO absorbing UART receive
// bursts while the command decoder is stalled; flags dropped bytes.
// Optional macro RXFIFO_STATS_EN adds a saturating 16-bit dropped-byte
// counter on port dropcnt.
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : rxfifo_if.slave (wdata, wen, rdata, rvalid, rready)
//   flush      : synchronous clear of contents
//   count      : entries held, 0..DEPTH
//   empty/full : count == 0 / count == DEPTH
//   overflow   : sticky, a write was dropped; cleared by ovclr
//   ovclr      : clears overflow (and dropcnt)
//   dropcnt    : dropped-byte count (RXFIFO_STATS_EN only)
module rxfifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  rxfifo_if.slave                    bus,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovclr
`ifdef RXFIFO_STATS_EN
  ,
  output logic [15:0]                dropcnt
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             pop;
  logic             push;
  logic             drop;

  assign empty      = (count == CW'(0));
  assign full       = (count == CW'(DEPTH));
  assign bus.rvalid = !empty;
  assign bus.rdata  = empty ? '0 : mem[rp];

  // Flush wins over everything; a pop frees the slot a full-FIFO write needs.
  assign pop  = !flush && !empty && bus.rready;
  assign push = !flush && bus.wen && (!full || pop);
  assign drop = !flush && bus.wen && full && !pop;

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= bus.wdata;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Sticky overflow; a drop in the same cycle as ovclr wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
    else if (ovclr) overflow <= 1'b0;
  end

`ifdef RXFIFO_STATS_EN
  // Saturating dropped-byte counter; a drop during ovclr restarts at 1.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dropcnt <= '0;
    end else if (drop) begin
      if (ovclr)                       dropcnt <= 16'd1;
      else if (dropcnt != 16'hFFFF)    dropcnt <= dropcnt + 16'd1;
    end else if (ovclr) begin
      dropcnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_rxfifo.sv
// tb_rxfifo: directed test-plan steps followed by random traffic, all
// checked against a queue-based model of the FIFO.
module tb_rxfifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned WIDTH = 8;

  logic        clk;
  logic        n_rst;
  logic        flush;
  logic        ovclr;
  logic [4:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
`ifdef RXFIFO_STATS_EN
  logic [15:0] dropcnt;
`endif

  rxfifo_if #(.WIDTH(WIDTH)) bus ();

  rxfifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bus      (bus.slave),
    .flush    (flush),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .ovclr    (ovclr)
`ifdef RXFIFO_STATS_EN
    ,
    .dropcnt  (dropcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ov;
  int         m_dc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".count"},    32'(count),      32'(q.size()));
    chk({tag, ".empty"},    32'(empty),      32'(q.size() == 0));
    chk({tag, ".full"},     32'(full),       32'(q.size() == DEPTH));
    chk({tag, ".rvalid"},   32'(bus.rvalid), 32'(q.size() != 0));
    chk({tag, ".rdata"},    32'(bus.rdata),  32'(head));
    chk({tag, ".overflow"}, 32'(overflow),   32'(m_ov));
`ifdef RXFIFO_STATS_EN
    chk({tag, ".dropcnt"},  32'(dropcnt),    32'(m_dc));
`endif
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check after.
  task automatic step(input logic w, input logic [7:0] d, input logic r,
                      input logic f, input logic c, input string tag);
    logic do_pop, do_push, do_drop;
    @(negedge clk);
    bus.wen = w; bus.wdata = d; bus.rready = r; flush = f; ovclr = c;
    @(posedge clk);
    do_pop = 1'b0; do_push = 1'b0; do_drop = 1'b0;
    if (f) begin
      q.delete();
    end else begin
      do_pop  = r && (q.size() != 0);
      do_push = w && ((q.size() < DEPTH) || do_pop);
      do_drop = w && !do_push;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(d);
    end
    if (do_drop) begin
      m_ov = 1'b1;
      m_dc = c ? 1 : ((m_dc < 65535) ? m_dc + 1 : 65535);
    end else if (c) begin
      m_ov = 1'b0;
      m_dc = 0;
    end
    #1;
    check_model(tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0;
    m_dc = 0;
  endtask

  initial begin
    n_rst = 1'b0; flush = 1'b0; ovclr = 1'b0;
    bus.wen = 1'b0; bus.wdata = '0; bus.rready = 1'b0;
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk);
    n_rst = 1'b1;

    // Three bytes in, then drained in order.
    step(1, 8'h41, 0, 0, 0, "tp1_w0");
    step(1, 8'h42, 0, 0, 0, "tp1_w1");
    step(1, 8'h43, 0, 0, 0, "tp1_w2");
    chk("tp1_cnt3", 32'(count), 32'd3);
    chk("tp1_head", 32'(bus.rdata), 32'h41);
    step(0, 8'h00, 1, 0, 0, "tp1_r0");
    chk("tp1_after_r0", 32'(bus.rdata), 32'h42);
    step(0, 8'h00, 1, 0, 0, "tp1_r1");
    step(0, 8'h00, 1, 0, 0, "tp1_r2");
    chk("tp1_empty", 32'(empty), 32'd1);
    chk("tp1_rdata0", 32'(bus.rdata), 32'd0);

    // Fill, overflow by one byte, drain.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, "tp2_fill");
    step(1, 8'hAA, 0, 0, 0, "tp2_drop");
    chk("tp2_ov", 32'(overflow), 32'd1);
    chk("tp2_cnt16", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("tp2_drain_data", 32'(bus.rdata), 32'(i));
      step(0, 8'h00, 1, 0, 0, "tp2_drain");
    end
    step(0, 8'h00, 0, 0, 1, "tp2_ovclr");
    chk("tp2_ovclr", 32'(overflow), 32'd0);

    // Full with simultaneous write and pop.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0, "tp3_fill");
    step(1, 8'h55, 1, 0, 0, "tp3_wr_pop");
    chk("tp3_cnt16", 32'(count), 32'd16);
    chk("tp3_noov", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("tp3_last", 32'(bus.rdata), 32'h55);
      step(0, 8'h00, 1, 0, 0, "tp3_drain");
    end

    // 20 writes with pops every other cycle, wrapping the pointers.
    for (int i = 0; i < 20; i++) step(1, 8'(8'h60 + i), 1'(i % 2), 0, 0, "tp4_wrap");
    for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 0, 0, "tp4_drain");

    // Flush with coincident write, then ovclr coincident with a drop.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0, 0, "tp5_fill");
    step(1, 8'hEE, 1, 1, 0, "tp5_flush");
    chk("tp5_cnt0", 32'(count), 32'd0);
    chk("tp5_ov_keep", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 8'(8'h90 + i), 0, 0, 0, "tp5_fill16");
    step(1, 8'hBB, 0, 0, 0, "tp5_drop1");
    step(1, 8'hCC, 0, 0, 1, "tp5_ovclr_drop");
    chk("tp5_ov_set", 32'(overflow), 32'd1);
    step(0, 8'h00, 0, 1, 0, "tp5_flush_ov");
    chk("tp5_ov_survives_flush", 32'(overflow), 32'd1);

    // Asynchronous reset mid-burst with 7 entries held.
    for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, "tp6_fill");
    chk("tp6_cnt7", 32'(count), 32'd7);
    @(negedge clk);
    bus.wen = 1'b1; bus.wdata = 8'hDD;
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    check_model("tp6_async_rst");
    chk("tp6_cnt0", 32'(count), 32'd0);
    @(negedge clk);
    bus.wen = 1'b0;
    n_rst = 1'b1;
    check_model("tp6_released");

    // Random traffic at several consumer speeds.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step(1'($urandom_range(99) < 60), 8'($urandom),
             1'($urandom_range(99) < 20 + 30 * ph),
             1'($urandom_range(99) < 2), 1'($urandom_range(99) < 3), "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
